// File: rtl/connect4_pkg.sv
// Shared types and helpers for the Connect Four board responder.
package connect4_pkg;

   localparam int unsigned ROWS_DEF    = 6;
   localparam int unsigned COLS_DEF    = 7;
   localparam int unsigned CONNECT_DEF = 4;

   typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_RESULT, ST_OVER} state_e;

   // Check order: horizontal, vertical, diagonal (+r,+c), anti-diagonal (+r,-c)
   typedef enum logic [1:0] {DIR_H, DIR_V, DIR_D, DIR_A} dir_e;

   function automatic int dir_dr(input dir_e d);
      return (d == DIR_H) ? 0 : 1;
   endfunction

   function automatic int dir_dc(input dir_e d);
      case (d)
         DIR_V:   return 0;
         DIR_A:   return -1;
         default: return 1;
      endcase
   endfunction

   function automatic int unsigned cell_idx(input int unsigned row, input int unsigned col,
                                            input int unsigned cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/connect4_run_counter.sv
// Counts consecutive owned cells from an origin along one direction and sense,
// stopping at the first gap or board edge, capped at CONNECT-1.
module connect4_run_counter
   import connect4_pkg::*;
#(
   parameter int unsigned ROWS    = ROWS_DEF,
   parameter int unsigned COLS    = COLS_DEF,
   parameter int unsigned CONNECT = CONNECT_DEF
) (
   input  logic [ROWS*COLS-1:0]         plane,
   input  logic [$clog2(ROWS)-1:0]      row,
   input  logic [$clog2(COLS)-1:0]      col,
   input  logic [1:0]                   dir,
   input  logic                         sense,
   output logic [$clog2(CONNECT)-1:0]   count
);

   localparam int unsigned IW = $clog2(ROWS * COLS);
   localparam int unsigned CW = $clog2(CONNECT);

   int   dr, dc, step, r, c;
   logic stop;

   always_comb begin
      dr    = dir_dr(dir_e'(dir));
      dc    = dir_dc(dir_e'(dir));
      step  = 0;
      r     = 0;
      c     = 0;
      stop  = 1'b0;
      count = '0;
      for (int k = 1; k < int'(CONNECT); k++) begin
         step = sense ? -k : k;
         r    = int'(row) + step * dr;
         c    = int'(col) + step * dc;
         if (stop || r < 0 || r >= int'(ROWS) || c < 0 || c >= int'(COLS))
            stop = 1'b1;
         else if (plane[IW'(r * int'(COLS) + c)])
            count = count + CW'(1);
         else
            stop = 1'b1;
      end
   end

endmodule

// File: rtl/connect4_board.sv
// Connect Four board: accepts column drops, then checks four directions through the new piece.
// Define CONNECT4_DRAW_EN to add a piece counter and the full-board draw result.
module connect4_board
   import connect4_pkg::*;
#(
   parameter int unsigned ROWS    = ROWS_DEF,
   parameter int unsigned COLS    = COLS_DEF,
   parameter int unsigned CONNECT = CONNECT_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     drop_req,
   input  logic [$clog2(COLS)-1:0]  column,
   input  logic                     player,
   output logic [1:0]               win,
   output logic                     draw,
   output logic                     busy,
   output logic                     done,
   output logic                     illegal,
   output logic [ROWS*COLS-1:0]     board_p0,
   output logic [ROWS*COLS-1:0]     board_p1
);

   localparam int unsigned NC  = ROWS * COLS;
   localparam int unsigned CIW = $clog2(COLS);
   localparam int unsigned RIW = $clog2(ROWS);
   localparam int unsigned HW  = $clog2(ROWS + 1);
   localparam int unsigned CW  = $clog2(CONNECT);

   state_e         state, state_nx;
   dir_e           dir;
   logic [HW-1:0]  height [COLS];
   logic [HW-1:0]  sel_height;
   logic           armed, hit, last_player;
   logic [RIW-1:0] last_row;
   logic [CIW-1:0] last_col;
   logic           col_ok, req_live, accept, reject, dir_hit, hit_any, full;
   logic [CW-1:0]  cnt_pos, cnt_neg;
   logic [NC-1:0]  check_plane;
   logic [1:0]     win_d;
   logic           draw_d, busy_d, done_d, illegal_d;

`ifdef CONNECT4_DRAW_EN
   localparam int unsigned PW = $clog2(NC + 1);
   logic [PW-1:0]  pieces;
   assign full = (pieces == PW'(NC));
`else
   assign full = 1'b0;
`endif

   always_comb begin
      sel_height = '0;
      for (int i = 0; i < int'(COLS); i++)
         if (column == CIW'(i)) sel_height = height[i];
   end

   assign col_ok      = (32'(column) < COLS);
   assign req_live    = (state == ST_IDLE) && drop_req && armed;
   assign accept      = req_live && col_ok && (sel_height != HW'(ROWS));
   assign reject      = req_live && !accept;
   assign check_plane = last_player ? board_p1 : board_p0;
   assign dir_hit     = (32'(cnt_pos) + 32'(cnt_neg) + 32'd1) >= CONNECT;
   assign hit_any     = hit | dir_hit;

   connect4_run_counter #(.ROWS(ROWS), .COLS(COLS), .CONNECT(CONNECT)) u_run_pos (
      .plane(check_plane), .row(last_row), .col(last_col), .dir(dir), .sense(1'b0), .count(cnt_pos)
   );

   connect4_run_counter #(.ROWS(ROWS), .COLS(COLS), .CONNECT(CONNECT)) u_run_neg (
      .plane(check_plane), .row(last_row), .col(last_col), .dir(dir), .sense(1'b1), .count(cnt_neg)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (accept) state_nx = ST_CHECK;
         ST_CHECK:  if (dir == DIR_A) state_nx = ST_RESULT;
         ST_RESULT: state_nx = (hit || full) ? ST_OVER : ST_IDLE;
         default:   state_nx = ST_OVER;
      endcase
   end

   // Result outputs are loaded on the last check edge so they coincide with done
   always_comb begin
      win_d     = win;
      draw_d    = draw;
      done_d    = 1'b0;
      illegal_d = reject;
      busy_d    = (state_nx == ST_CHECK) || (state_nx == ST_RESULT);
      if (state == ST_CHECK && dir == DIR_A) begin
         done_d = 1'b1;
         if (hit_any)   win_d  = {1'b1, last_player};
         else if (full) draw_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win         <= '0;
         draw        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         illegal     <= 1'b0;
         board_p0    <= '0;
         board_p1    <= '0;
         for (int i = 0; i < int'(COLS); i++) height[i] <= '0;
         armed       <= 1'b1;
         hit         <= 1'b0;
         last_player <= 1'b0;
         last_row    <= '0;
         last_col    <= '0;
         dir         <= DIR_H;
`ifdef CONNECT4_DRAW_EN
         pieces      <= '0;
`endif
      end else begin
         win     <= win_d;
         draw    <= draw_d;
         busy    <= busy_d;
         done    <= done_d;
         illegal <= illegal_d;
         // A held request is serviced once; a low cycle re-arms it
         if (!drop_req)     armed <= 1'b1;
         else if (req_live) armed <= 1'b0;
         if (accept) begin
            if (player) board_p1 <= board_p1 | (NC'(1) << cell_idx(32'(sel_height), 32'(column), COLS));
            else        board_p0 <= board_p0 | (NC'(1) << cell_idx(32'(sel_height), 32'(column), COLS));
            for (int i = 0; i < int'(COLS); i++)
               if (column == CIW'(i)) height[i] <= sel_height + HW'(1);
            last_row    <= RIW'(sel_height);
            last_col    <= column;
            last_player <= player;
            dir         <= DIR_H;
            hit         <= 1'b0;
`ifdef CONNECT4_DRAW_EN
            pieces      <= pieces + PW'(1);
`endif
         end else if (state == ST_CHECK) begin
            hit <= hit_any;
            dir <= dir_e'(dir + 2'd1);
         end
      end
   end

endmodule

// File: doc/connect4_board.md
# connect4_board

Board-state responder to the game controller FSM. It holds the Connect Four grid and accepts column-select drop requests. For each legal drop it places the current player's piece in the lowest empty row and runs a multi-cycle four-in-a-row check through the new piece. It reports the result on `win[1:0]`, which feeds straight back into the controller's `win` input (the controller reads `win[1]` as "game won").

## Interface
Parameters:
- `ROWS`, default 6: board height; row 0 is the bottom.
- `COLS`, default 7: board width.
- `CONNECT`, default 4: run length that wins.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears the board, counters and all outputs.
- `drop_req` in 1: level request from the controller's `sel_column`.
- `column` in $clog2(COLS): target column, sampled with `drop_req`.
- `player` in 1: owner of the piece being dropped, sampled with `drop_req`.
- `win` out 2: `{won, winner}`; `win[1]` = game won (sticky), `win[0]` = winning player.
- `draw` out 1: board full with no winner (sticky); only when `CONNECT4_DRAW_EN` is defined.
- `busy` out 1: high from the cycle after acceptance until the cycle after `done`.
- `done` out 1: one-cycle pulse when a drop's check completes.
- `illegal` out 1: one-cycle pulse when a request is rejected.
- `board_p0`, `board_p1` out ROWS*COLS: occupancy bit-planes for display; cell index = row*COLS + col.

## Operation
- States: IDLE, CHECK, RESULT, OVER.
- Per-column height counters, each $clog2(ROWS+1) bits, plus an `armed` flag. `armed` resets to 1.
- IDLE, `drop_req` & `armed`:
  - If `column` ≥ COLS, or `height[column]` == ROWS: pulse `illegal`, clear `armed`, stay IDLE. Board is unchanged.
  - Otherwise: set bit (height, column) in `player`'s plane, increment the height, latch last row/col/player, clear `armed`, go to CHECK with dir=0.
- `armed` sets again on any cycle where `drop_req` is low. A held level therefore produces exactly one drop.
- CHECK runs 4 cycles, one direction per cycle: horizontal, vertical, diagonal (+row,+col), anti-diagonal (+row,−col).
  - Each cycle counts consecutive same-player cells from the last piece in both senses, up to CONNECT−1 each, clipped at the board edges.
  - Run = count+ + count− + 1. The hit flag ORs in (run ≥ CONNECT).
- RESULT: pulse `done`.
  - If hit: `win` ← {1, last player}, go to OVER.
  - Else if the board is full and `CONNECT4_DRAW_EN` is defined: `draw` ← 1, go to OVER.
  - Else: go to IDLE.
- OVER: all `drop_req` ignored (no `illegal`). Outputs are held until `reset`.
- `column` and `player` are don't-care outside IDLE acceptance.

## Timing
- Reset values: `win`=00, `draw`=0, `busy`=0, `done`=0, `illegal`=0, both planes all-zero, heights 0, state IDLE.
- Drop accepted at edge E0. `busy`=1 after E0; the board planes show the new piece after E0.
- CHECK evaluates at E1..E4. RESULT occupies the cycle after E4: `done`=1, and `win`/`draw` are valid in that same cycle.
- Earliest next accept is at E6, and only if `drop_req` was low at some edge after E0.
- `illegal` asserts in the cycle after the rejecting edge, for exactly 1 cycle.
- A `reset` asserted mid-CHECK aborts immediately. No `done` is issued and the board is empty.

## Configuration
- `CONNECT4_DRAW_EN` defined: a piece counter ($clog2(ROWS*COLS+1) bits) increments on each placement. Reaching ROWS*COLS without a hit asserts `draw` and enters OVER.
- Not defined: no piece counter; `draw` tied 0. A full board stays in IDLE, and every request is rejected as a full column.

## Structure
- Package `connect4_pkg`:
  - ROWS/COLS/CONNECT defaults;
  - state enum and direction enum (dr/dc step constants);
  - cell-index function.
- Sub-module `connect4_run_counter`: combinational. Given a plane, origin, direction step and sense, it returns the clipped same-owner count (0..CONNECT−1). Two instances are used, one per sense.

## Test plan
- Player 0 drops column 3 four times (each request high 1 cycle, low 1 cycle) → fourth `done` has `win`=10; state OVER; a fifth request gives no `illegal` and no board change.
- Player 1 fills row 0 in columns 0,1,2,3 (player 0's pieces stacked in column 6 in between) → `win`=11 on the fourth player-1 `done`, exactly 5 cycles after acceptance.
- Diagonal (0,0),(1,1),(2,2),(3,3) for player 0, with filler pieces → win on the last placement. Mirror the same check for the anti-diagonal.
- 7th drop into column 2 (full) → `illegal` pulse, `board_p0`/`board_p1` unchanged, `busy` stays 0. `column`=7 → `illegal`.
- `drop_req` held high for 20 cycles → exactly one placement and one `done`. Assert `reset` during CHECK → outputs return to zero, with no `done`.
- `CONNECT4_DRAW_EN`: fill all 42 cells with a no-win pattern → `draw`=1 with the final `done`, `win`=00.
